pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (F/D/E/M/W).
- Compares D-stage operand demand (Tuse) against E/M producer supply (Tnew) and generates F/D register enables and the E-register clear (bubble insert).
- Owns the multiply/divide unit (MDU) busy countdown, so that D-stage MDU instructions stall while a mult/div is in flight.
- W stage is never a stall source; W results always reach D via the forwarding path.

Parameters:
- MULT_CYCLES, 5, busy cycles loaded on a mult/multu start
- DIV_CYCLES, 10, busy cycles loaded on a div/divu start
- CNT_W, 4, width of MDU countdown; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clk
- D_rs_addr  in  5  rs register index of instruction in D
- D_rt_addr  in  5  rt register index of instruction in D
- D_tuse_rs  in  2  cycles until D needs rs (0..2); 3 = rs unused
- D_tuse_rt  in  2  cycles until D needs rt (0..2); 3 = rt unused
- D_is_md  in  1  instruction in D uses MDU (mult/div/mfhi/mflo/mthi/mtlo)
- E_A3  in  5  destination register of instruction in E (0 = none)
- E_tnew  in  2  cycles until E result is forwardable
- M_A3  in  5  destination register of instruction in M
- M_tnew  in  2  cycles until M result is forwardable
- E_md_start  in  1  instruction in E starts a mult/div this cycle
- E_md_div  in  1  qualifies E_md_start: 1 = div, 0 = mult
- stall  out  1  D instruction held this cycle
- F_en  out  1  PC / F-D register write enable (= ~stall)
- D_en  out  1  D-E register write enable (= ~stall)
- E_clr  out  1  clear D-E register, inserting a bubble (= stall)
- md_busy  out  1  MDU occupied
- md_count  out  CNT_W  remaining MDU busy cycles

Behaviour:
- Data hazard, combinational, per operand X in {rs, rt}:
  - hazX = (D_X_addr != 0) & ((D_X_addr == E_A3 & E_tnew > D_tuse_X) | (D_X_addr == M_A3 & M_tnew > D_tuse_X)).
  - Tuse = 3 never stalls, since Tnew ≤ 2.
- MDU counter, registered md_count, reset 0:
  - E_md_start & md_count == 0: load DIV_CYCLES if E_md_div, else MULT_CYCLES.
  - Else if md_count != 0: decrement by 1 each cycle.
  - E_md_start while md_count != 0 is ignored; the counter is not reloaded. This is unreachable under correct stalling.
- md_busy = (md_count != 0) | E_md_start. The start cycle itself counts as busy.
- stall = hazrs | hazrt | (D_is_md & md_busy).
- When stalled, the D instruction repeats next cycle, E receives a bubble, and the PC holds.
- Latency:
  - Stalls are asserted the same cycle the condition exists.
  - A mult started in cycle t keeps D_is_md stalled for cycles t..t+MULT_CYCLES.
  - The first non-stalled cycle is t+MULT_CYCLES+1.
- During the reset cycle:
  - stall = 0, F_en = D_en = 1, E_clr = 0, md_busy = 0, regardless of inputs.
  - md_count = 0 after the edge.
- Reset asserted mid-countdown: md_count returns to 0 on that edge and any in-flight op is abandoned.
- Simultaneous data hazard and MDU hazard: a single stall; no priority distinction is needed.
- Identical hazard from both E and M: E match suffices; the result is the same.

Optional Feature:
- Macro STALL_STAT_EN.
- Defined:
  - Adds output stall_cycles (32-bit) and output md_stall_cycles (32-bit).
  - stall_cycles increments each cycle stall = 1.
  - md_stall_cycles increments each cycle the stall is MDU-caused only.
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - TUSE_NONE = 2'd3
  - TNEW width = 2
  - REG_ZERO = 5'd0
  - MULT_CYCLES and DIV_CYCLES defaults
  - a typedef for the 5-bit register index
- One sub-module, md_busy_cnt: the load/decrement counter producing md_count/md_busy.
- The hazard compare stays inline.

Test Plan:
- Load-use: E_A3=8, E_tnew=2, D_rs_addr=8, D_tuse_rs=1 -> stall=1, E_clr=1, F_en=0. Next cycle with M_A3=8, M_tnew=1 -> stall=0.
- $0 immunity: E_A3=0, E_tnew=2, D_rs_addr=0, D_tuse_rs=0 -> stall=0.
- Tuse sufficiency: M_A3=5, M_tnew=1, D_rt_addr=5, D_tuse_rt=1 -> stall=0. Same with D_tuse_rt=0 -> stall=1.
- Mult countdown: E_md_start=1, E_md_div=0 at cycle 0 with D_is_md=1 held:
  - md_count reads 5,4,3,2,1,0 on cycles 1..6.
  - stall=1 for cycles 0..5; stall=0 at cycle 6.
- Div with overlapping start: start div at cycle 0, pulse E_md_start at cycle 3 -> md_count stays 10,9,8,7,... with no reload.
- Reset mid-div: reset=1 at md_count=6 -> md_count=0 next cycle, md_busy=0, stall=0 during reset. Under STALL_STAT_EN, counters read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 5-stage pipeline stall/flush logic.
//   TUSE_NONE        : Tuse code meaning "operand not read"
//   TNEW_W / tnew_t  : width and type of Tuse/Tnew timing codes
//   reg_idx_t        : 5-bit architectural register index
//   REG_ZERO         : index of the hard-wired zero register
//   *_DEF            : default MDU latencies and countdown width
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int TNEW_W = 2;
    typedef logic [TNEW_W-1:0] tnew_t;

    typedef logic [4:0] reg_idx_t;

    localparam tnew_t    TUSE_NONE = 2'd3;
    localparam reg_idx_t REG_ZERO  = 5'd0;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

    // Busy-cycle count to load for an MDU start; div takes the longer path.
    function automatic int md_load_cycles(input logic is_div, input int mult_cycles,
                                          input int div_cycles);
        int result;
        if (is_div) begin
            result = div_cycles;
        end else begin
            result = mult_cycles;
        end
        return result;
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// -----------------------------------------------------------------------------
// md_busy_cnt
// Multiply/divide unit occupancy countdown.
// Ports:
//   clk    in  : pipeline clock
//   reset  in  : synchronous active-high reset
//   start  in  : E-stage instruction starts a mult/div this cycle
//   is_div in  : qualifies start (1 = div, 0 = mult)
//   count  out : remaining MDU busy cycles (registered)
//   busy   out : MDU occupied; includes the start cycle, forced low in reset
// A start that arrives while the counter is still running is ignored; correct
// stalling upstream never lets that happen, so the in-flight op wins.
// -----------------------------------------------------------------------------
module md_busy_cnt
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MULT_LOAD =
        CNT_W'(md_load_cycles(1'b0, MULT_CYCLES, DIV_CYCLES));
    localparam logic [CNT_W-1:0] DIV_LOAD  =
        CNT_W'(md_load_cycles(1'b1, MULT_CYCLES, DIV_CYCLES));

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             idle_s;
    logic             busy_s;

    // Next-count selection: load on an accepted start, otherwise run down to zero.
    always_comb begin
        count_nxt_s = count_r;
        idle_s      = (count_r == CNT_ZERO);
        if (start && idle_s) begin
            if (is_div) begin
                count_nxt_s = DIV_LOAD;
            end else begin
                count_nxt_s = MULT_LOAD;
            end
        end else if (!idle_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Countdown register; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_nxt_s;
        end
    end

    // Busy flag: the start cycle itself already occupies the unit.
    always_comb begin
        busy_s = 1'b0;
        if (reset) begin
            busy_s = 1'b0;
        end else begin
            busy_s = (count_r != CNT_ZERO) | start;
        end
    end

    assign count = count_r;
    assign busy  = busy_s;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
// Central stall/flush sequencer for the F/D/E/M/W pipeline. Compares the
// D-stage operand demand (Tuse) with E/M producer supply (Tnew), and holds D
// while the MDU is busy for an MDU instruction. W never stalls: its result is
// always forwarded.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   D_rs_addr/D_rt_addr   : D-stage source register indices
//   D_tuse_rs/D_tuse_rt   : cycles until D needs the operand (3 = unused)
//   D_is_md               : D instruction uses the MDU
//   E_A3/E_tnew           : E-stage destination and cycles until forwardable
//   M_A3/M_tnew           : M-stage destination and cycles until forwardable
//   E_md_start/E_md_div   : E starts a mult/div this cycle; 1 = div
//   stall                 : D instruction held this cycle
//   F_en/D_en             : PC/F-D and D-E register enables (= ~stall)
//   E_clr                 : clear D-E register, inserting a bubble (= stall)
//   md_busy/md_count      : MDU occupied / remaining busy cycles
// Optional (macro STALL_STAT_EN):
//   stall_cycles          : free-running count of stalled cycles
//   md_stall_cycles       : count of cycles stalled by the MDU alone
// Stall outputs are combinational so the hold takes effect in the same cycle
// the hazard exists.
// -----------------------------------------------------------------------------
module pipe_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       D_rs_addr,
    input  logic [4:0]       D_rt_addr,
    input  logic [1:0]       D_tuse_rs,
    input  logic [1:0]       D_tuse_rt,
    input  logic             D_is_md,
    input  logic [4:0]       E_A3,
    input  logic [1:0]       E_tnew,
    input  logic [4:0]       M_A3,
    input  logic [1:0]       M_tnew,
    input  logic             E_md_start,
    input  logic             E_md_div,
    output logic             stall,
    output logic             F_en,
    output logic             D_en,
    output logic             E_clr,
    output logic             md_busy,
    output logic [CNT_W-1:0] md_count
`ifdef STALL_STAT_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      md_stall_cycles
`endif
);

    logic haz_rs_s;
    logic haz_rt_s;
    logic data_haz_s;
    logic md_haz_s;
    logic md_busy_s;
    logic stall_s;

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_cnt (
        .clk    (clk),
        .reset  (reset),
        .start  (E_md_start),
        .is_div (E_md_div),
        .count  (md_count),
        .busy   (md_busy_s)
    );

    // Per-operand Tuse/Tnew compare against the E and M producers. An unused
    // operand (TUSE_NONE) can never stall because no Tnew exceeds it; the
    // explicit term just makes that visible. $0 is never a real dependency.
    always_comb begin
        haz_rs_s = 1'b0;
        haz_rt_s = 1'b0;
        if ((D_rs_addr != REG_ZERO) && (D_tuse_rs != TUSE_NONE)) begin
            haz_rs_s = ((D_rs_addr == E_A3) && (E_tnew > D_tuse_rs)) ||
                       ((D_rs_addr == M_A3) && (M_tnew > D_tuse_rs));
        end else begin
            haz_rs_s = 1'b0;
        end
        if ((D_rt_addr != REG_ZERO) && (D_tuse_rt != TUSE_NONE)) begin
            haz_rt_s = ((D_rt_addr == E_A3) && (E_tnew > D_tuse_rt)) ||
                       ((D_rt_addr == M_A3) && (M_tnew > D_tuse_rt));
        end else begin
            haz_rt_s = 1'b0;
        end
    end

    // Merge data and MDU hazards into one stall; reset forces the pipe to flow.
    always_comb begin
        data_haz_s = haz_rs_s | haz_rt_s;
        md_haz_s   = D_is_md & md_busy_s;
        stall_s    = 1'b0;
        if (reset) begin
            stall_s = 1'b0;
        end else begin
            stall_s = data_haz_s | md_haz_s;
        end
    end

    assign stall   = stall_s;
    assign F_en    = ~stall_s;
    assign D_en    = ~stall_s;
    assign E_clr   = stall_s;
    assign md_busy = md_busy_s;

`ifdef STALL_STAT_EN
    logic [31:0] stall_cycles_r;
    logic [31:0] md_stall_cycles_r;

    // Stall statistics; a cycle counts as MDU-caused only with no data hazard.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_r    <= 32'd0;
            md_stall_cycles_r <= 32'd0;
        end else begin
            if (stall_s) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (stall_s && md_haz_s && !data_haz_s) begin
                md_stall_cycles_r <= md_stall_cycles_r + 32'd1;
            end else begin
                md_stall_cycles_r <= md_stall_cycles_r;
            end
        end
    end

    assign stall_cycles    = stall_cycles_r;
    assign md_stall_cycles = md_stall_cycles_r;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Directed scenarios followed by randomized traffic, checked against a
// cycle-indexed reference model: the MDU is described by the cycle at which it
// becomes free, and hazards are evaluated straight from the Tuse/Tnew rules.
// Optional statistics outputs are checked when STALL_STAT_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

    localparam int MULT = 5;
    localparam int DIV  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs_addr, D_rt_addr, E_A3, M_A3;
    logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic       D_is_md, E_md_start, E_md_div;
    logic       stall, F_en, D_en, E_clr, md_busy;
    logic [3:0] md_count;
`ifdef STALL_STAT_EN
    logic [31:0] stall_cycles, md_stall_cycles;
`endif

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs_addr  (D_rs_addr),
        .D_rt_addr  (D_rt_addr),
        .D_tuse_rs  (D_tuse_rs),
        .D_tuse_rt  (D_tuse_rt),
        .D_is_md    (D_is_md),
        .E_A3       (E_A3),
        .E_tnew     (E_tnew),
        .M_A3       (M_A3),
        .M_tnew     (M_tnew),
        .E_md_start (E_md_start),
        .E_md_div   (E_md_div),
        .stall      (stall),
        .F_en       (F_en),
        .D_en       (D_en),
        .E_clr      (E_clr),
        .md_busy    (md_busy),
        .md_count   (md_count)
`ifdef STALL_STAT_EN
        ,
        .stall_cycles    (stall_cycles),
        .md_stall_cycles (md_stall_cycles)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int cyc      = 0;   // cycle index since the model was synchronised
    int free_cyc = 0;   // first cycle at which the MDU count reads zero
    int st_total = 0;
    int md_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0;
        D_rs_addr = 5'd0; D_rt_addr = 5'd0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
        D_is_md = 1'b0; E_A3 = 5'd0; E_tnew = 2'd0; M_A3 = 5'd0; M_tnew = 2'd0;
        E_md_start = 1'b0; E_md_div = 1'b0;
    endtask

    function automatic bit operand_wait(input int src, input int tuse);
        return (src != 0) &&
               ((src == int'(E_A3) && int'(E_tnew) > tuse) ||
                (src == int'(M_A3) && int'(M_tnew) > tuse));
    endfunction

    // One clock cycle with the currently driven inputs. exp_stall / exp_cnt
    // add literal expectations from the scenario (-1 = none).
    task automatic step(input int exp_stall, input int exp_cnt);
        int cnt;
        bit hz_rs, hz_rt, busy, st;
        #2;
        cnt   = (free_cyc > cyc) ? (free_cyc - cyc) : 0;
        hz_rs = operand_wait(int'(D_rs_addr), int'(D_tuse_rs));
        hz_rt = operand_wait(int'(D_rt_addr), int'(D_tuse_rt));
        busy  = !reset && (cnt != 0 || E_md_start);
        st    = !reset && (hz_rs || hz_rt || (D_is_md && busy));
        check("stall",    32'(stall),    32'(st));
        check("F_en",     32'(F_en),     32'(!st));
        check("D_en",     32'(D_en),     32'(!st));
        check("E_clr",    32'(E_clr),    32'(st));
        check("md_busy",  32'(md_busy),  32'(busy));
        check("md_count", 32'(md_count), 32'(cnt));
        if (exp_stall >= 0) check("plan_stall", 32'(stall), 32'(exp_stall));
        if (exp_cnt >= 0)   check("plan_count", 32'(md_count), 32'(exp_cnt));
`ifdef STALL_STAT_EN
        check("stall_cycles",    stall_cycles,    32'(st_total));
        check("md_stall_cycles", md_stall_cycles, 32'(md_total));
`endif
        @(posedge clk);
        if (reset) begin
            free_cyc = cyc + 1;
            st_total = 0;
            md_total = 0;
        end else begin
            if (E_md_start && cnt == 0)
                free_cyc = cyc + 1 + (E_md_div ? DIV : MULT);
            if (st) st_total++;
            if (st && !hz_rs && !hz_rt) md_total++;
        end
        cyc++;
        #1;
    endtask

    initial begin
        // Reset cycle with a live hazard and MDU start: outputs must stay flowing.
        idle_inputs();
        reset = 1'b1;
        E_A3 = 5'd8; E_tnew = 2'd2; D_rs_addr = 5'd8; D_tuse_rs = 2'd0;
        D_is_md = 1'b1; E_md_start = 1'b1;
        #2;
        check("rst_stall",   32'(stall),   32'd0);
        check("rst_F_en",    32'(F_en),    32'd1);
        check("rst_D_en",    32'(D_en),    32'd1);
        check("rst_E_clr",   32'(E_clr),   32'd0);
        check("rst_md_busy", 32'(md_busy), 32'd0);
        @(posedge clk);
        #1;
        cyc = 0; free_cyc = 0; st_total = 0; md_total = 0;
        idle_inputs();
        step(0, 0);

        // Load-use from E, then resolved once the producer sits in M with Tnew=1.
        E_A3 = 5'd8; E_tnew = 2'd2; D_rs_addr = 5'd8; D_tuse_rs = 2'd1;
        step(1, -1);
        E_A3 = 5'd0; E_tnew = 2'd0; M_A3 = 5'd8; M_tnew = 2'd1;
        step(0, -1);

        // $0 never creates a dependency.
        idle_inputs();
        E_A3 = 5'd0; E_tnew = 2'd2; D_rs_addr = 5'd0; D_tuse_rs = 2'd0;
        step(0, -1);

        // Tuse sufficiency on rt against an M producer.
        idle_inputs();
        M_A3 = 5'd5; M_tnew = 2'd1; D_rt_addr = 5'd5; D_tuse_rt = 2'd1;
        step(0, -1);
        D_tuse_rt = 2'd0;
        step(1, -1);

        // Same register produced by both E and M.
        idle_inputs();
        E_A3 = 5'd9; E_tnew = 2'd1; M_A3 = 5'd9; M_tnew = 2'd1; D_rs_addr = 5'd9; D_tuse_rs = 2'd0;
        step(1, -1);

        // Mult countdown with D_is_md held.
        idle_inputs();
        D_is_md = 1'b1; E_md_start = 1'b1; E_md_div = 1'b0;
        step(1, 0);
        E_md_start = 1'b0;
        for (int k = 1; k <= 6; k++) step((k <= 5) ? 1 : 0, 6 - k);

        // Div with a stray start in the middle, then reset at count 6.
        idle_inputs();
        E_md_start = 1'b1; E_md_div = 1'b1;
        step(-1, 0);
        E_md_start = 1'b0;
        step(-1, 10);
        step(-1, 9);
        E_md_start = 1'b1; E_md_div = 1'b0;
        step(-1, 8);
        E_md_start = 1'b0;
        step(-1, 7);
        reset = 1'b1; D_is_md = 1'b1; E_A3 = 5'd3; E_tnew = 2'd2; D_rs_addr = 5'd3; D_tuse_rs = 2'd0;
        step(0, 6);
        idle_inputs();
        step(0, 0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            D_rs_addr  = 5'($urandom_range(0, 3));
            D_rt_addr  = 5'($urandom_range(0, 3));
            D_tuse_rs  = 2'($urandom_range(0, 3));
            D_tuse_rt  = 2'($urandom_range(0, 3));
            D_is_md    = ($urandom_range(0, 3) == 0);
            E_A3       = 5'($urandom_range(0, 3));
            E_tnew     = 2'($urandom_range(0, 2));
            M_A3       = 5'($urandom_range(0, 3));
            M_tnew     = 2'($urandom_range(0, 2));
            E_md_start = ($urandom_range(0, 7) == 0);
            E_md_div   = 1'($urandom_range(0, 1));
            step(-1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
